// File: rtl/uart_out_if.sv
// Byte handshake between internal logic and the UART transmitter FIFO.
interface uart_out_if;
    logic [7:0] byte_out;
    logic       send;
    logic       ready;

    modport master (output byte_out, output send, input ready);
    modport slave  (input byte_out, input send, output ready);
endinterface

// File: rtl/uart_out.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
module uart_out #(
    parameter int DELAY_FRAMES = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_out_if.slave bus,
    output logic     uart_tx,
    output logic     busy,
    output logic     tx_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      LAST_CNT = 16'(DELAY_FRAMES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic push;
    logic pop;
    logic bit_end;
    logic fifo_empty;

    assign bus.ready  = (count_q != FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign bit_end    = (cnt_q == LAST_CNT);
    assign push       = bus.send && (count_q != FULL_CNT);

    assign uart_tx = tx_q;
    assign busy    = (state_q != S_IDLE);
    assign tx_done = (state_q == S_STOP) && bit_end;

    // Transmit FSM: pops a byte, then walks start, eight data bits and stop, one bit period each.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = 3'd0;
                    cnt_d     = 16'd0;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_idx_d = 3'd0;
                        state_d   = S_START;
                        tx_d      = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    // FIFO bookkeeping: pointers wrap naturally because the depth is a power of two.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.byte_out;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // State registers; reset aborts any frame and drops buffered bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: doc/uart_out.md
Name: uart_out

Overview:
- 8N1 UART transmitter: the transmit-side companion of the on-board UART receive path.
- Accepts bytes from internal logic through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte onto `uart_tx` at the baud rate given by `DELAY_FRAMES`.
- Used by the LCD/text designs to echo characters and report status to the host at 115200 baud from the 27 MHz clock.

Parameters:
- DELAY_FRAMES, 234, clocks per bit period (27,000,000 / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of two, 2..16.

Ports:
- clk  input  1  system clock (27 MHz)
- rst_n  input  1  asynchronous active-low reset
- byte_out  input  8  byte to transmit
- send  input  1  byte_out valid
- ready  output  1  FIFO can accept a byte this cycle
- uart_tx  output  1  serial line, idle high
- busy  output  1  transmitter FSM is not IDLE
- tx_done  output  1  one-cycle pulse at the end of each stop bit

Behaviour:
Reset (rst_n low, asynchronous):
- uart_tx=1, busy=0, tx_done=0, ready=1.
- FIFO emptied; FSM returns to IDLE; bit counter=0.
- Reset mid-frame aborts the frame immediately, the line returns high, and buffered bytes are discarded.

Handshake and FIFO:
- A byte is accepted on a rising edge where send=1 and ready=1.
- ready = (count != FIFO_DEPTH), derived from the registered count only.
- When the FIFO is full, send is ignored, even if a pop occurs in the same cycle.
- Push and pop in the same cycle (not full, not empty): count unchanged, data order preserved.
- Read and write pointers wrap modulo FIFO_DEPTH.
- byte_out is sampled only on the accepting edge.

Transmit FSM (states IDLE, START, DATA, STOP):
- IDLE:
  - uart_tx=1.
  - If FIFO non-empty: pop head into the shift register, bit index=0, cycle counter=0, go to START.
  - A byte pushed into an empty FIFO at edge N is popped at edge N+1; uart_tx goes low after edge N+1.
- START:
  - uart_tx=0 for exactly DELAY_FRAMES clocks, then go to DATA.
- DATA:
  - uart_tx = shift register bit 0 (LSB first).
  - Each bit is held exactly DELAY_FRAMES clocks, then the register shifts right and the bit index increments.
  - After bit 7 completes, go to STOP.
- STOP:
  - uart_tx=1 for exactly DELAY_FRAMES clocks.
  - On the last cycle, tx_done pulses for one clock.
  - If the FIFO is non-empty: pop and go directly to START (no idle gap between frames).
  - Otherwise go to IDLE.

Timing and arithmetic:
- One frame = exactly 10*DELAY_FRAMES clocks.
- Cycle counter is 16 bits; it counts 0..DELAY_FRAMES-1 and resets to 0 at each bit boundary.
- busy=1 in START, DATA and STOP.
- uart_tx is driven from a register (glitch-free).
- send during an active frame only affects the FIFO; the frame in flight is never altered.

Test Plan (DELAY_FRAMES=8, FIFO_DEPTH=4 unless stated):
1. Single byte 0x55 pushed into an idle block:
   - uart_tx low from edge N+1 for 8 clocks.
   - Then bits 1,0,1,0,1,0,1,0 with 8 clocks each, then stop high for 8 clocks.
   - tx_done pulses once at clock 80 of the frame; busy high for 80 clocks.
2. Back-to-back 0x41 then 0x42 pushed on consecutive cycles:
   - Two frames, 160 contiguous clocks with no idle-high gap.
   - Decoded by the bench receiver as 0x41, 0x42.
3. Overflow: push 6 bytes 0x01..0x06 on consecutive cycles while the first frame is active:
   - 0x01 popped; 0x02..0x05 fill the FIFO, so ready=0 and 0x06 is dropped.
   - Line carries exactly 0x01..0x05 in order.
4. Simultaneous push/pop:
   - Push on the exact STOP-end cycle with 1 byte queued.
   - Count is unchanged; byte order is preserved across pointer wrap (run 10 bytes through).
5. Reset mid-frame: assert rst_n=0 during DATA bit 3 with 2 bytes queued:
   - uart_tx=1 and busy=0 asynchronously; ready=1.
   - After release, no further transmission occurs.
6. DELAY_FRAMES=234: byte 0xA5 frame lasts exactly 2340 clocks and is decoded correctly by a 115200-baud bench model.
